elevator_dispatcher: RTL

ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

---
 rtl/elevator_dispatcher.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/elevator_dispatcher.sv
// Two-car hall-call dispatcher: latches hall calls, offers the lowest unassigned call
// to the better-placed eligible car, and tracks per-floor ownership until served.
module elevator_dispatcher #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] hall_req_i,
   input  logic [1:0] car0_floor_i,
   input  logic [1:0] car1_floor_i,
   input  logic       car0_busy_i,
   input  logic       car1_busy_i,
   input  logic       assign_ack0_i,
   input  logic       assign_ack1_i,
   input  logic       done0_i,
   input  logic       done1_i,
   input  logic [1:0] done_floor0_i,
   input  logic [1:0] done_floor1_i,
   output logic       assign_valid0_o,
   output logic       assign_valid1_o,
   output logic [1:0] assign_floor_o,
   output logic [3:0] pending_o,
   output logic [3:0] assigned_o,
   output logic [3:0] owner_o,
   output logic       timeout_pulse_o
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t     state_q;
   logic [3:0] pending_q, assigned_q, owner_q;
   logic [3:0] pending_d, assigned_d, owner_d;
   logic [7:0] wait_q;
   logic       rr_q, excl_vld_q, excl_car_q, offer_car_q;
   logic       valid0_q, valid1_q, pulse_q;
   logic [1:0] floor_q;

   logic [3:0] free;
   logic       cand_found;
   logic [1:0] cand_floor;
   logic       elig0, elig1, pick_car, ack_hit;
   logic [1:0] dist0, dist1;

   function automatic logic [1:0] floor_dist(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   assign free = pending_q & ~assigned_q;

   // Scan downward so the lowest free floor is the last (and final) match.
   always_comb begin
      cand_found = 1'b0;
      cand_floor = 2'd0;
      for (int f = 3; f >= 0; f--) begin
         if (free[f]) begin
            cand_found = 1'b1;
            cand_floor = 2'(f);
         end
      end
   end

   assign elig0 = ~car0_busy_i & ~(excl_vld_q & ~excl_car_q);
   assign elig1 = ~car1_busy_i & ~(excl_vld_q &  excl_car_q);
   assign dist0 = floor_dist(cand_floor, car0_floor_i);
   assign dist1 = floor_dist(cand_floor, car1_floor_i);

   always_comb begin
      if (elig0 && !elig1)      pick_car = 1'b0;
      else if (elig1 && !elig0) pick_car = 1'b1;
      else if (dist0 != dist1)  pick_car = (dist1 < dist0);
      else                      pick_car = rr_q;
   end

   assign ack_hit = (state_q == OFFER) && (offer_car_q ? assign_ack1_i : assign_ack0_i);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_floor
         logic clr0, clr1, accept;
         assign clr0   = done0_i && (done_floor0_i == 2'(gi)) && assigned_q[gi] && !owner_q[gi];
         assign clr1   = done1_i && (done_floor1_i == 2'(gi)) && assigned_q[gi] &&  owner_q[gi];
         assign accept = ack_hit && (floor_q == 2'(gi));
         // A hall call arriving with the clear re-opens the floor as pending but unowned.
         assign pending_d[gi]  = hall_req_i[gi] | (pending_q[gi] & ~(clr0 | clr1));
         assign assigned_d[gi] = accept | (assigned_q[gi] & ~(clr0 | clr1));
         assign owner_d[gi]    = accept ? offer_car_q : owner_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         assigned_q  <= '0;
         owner_q     <= '0;
         wait_q      <= '0;
         rr_q        <= 1'b0;
         excl_vld_q  <= 1'b0;
         excl_car_q  <= 1'b0;
         offer_car_q <= 1'b0;
         valid0_q    <= 1'b0;
         valid1_q    <= 1'b0;
         pulse_q     <= 1'b0;
         floor_q     <= '0;
      end else begin
         pending_q  <= pending_d;
         assigned_q <= assigned_d;
         owner_q    <= owner_d;
         pulse_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cand_found && (elig0 || elig1)) begin
                  state_q     <= OFFER;
                  offer_car_q <= pick_car;
                  floor_q     <= cand_floor;
                  valid0_q    <= ~pick_car;
                  valid1_q    <= pick_car;
                  wait_q      <= '0;
                  excl_vld_q  <= 1'b0;
               end else if (!cand_found) begin
                  excl_vld_q <= 1'b0;
               end
            end
            OFFER: begin
               if (ack_hit) begin
                  valid0_q <= 1'b0;
                  valid1_q <= 1'b0;
                  rr_q     <= ~offer_car_q;
                  state_q  <= IDLE;
               end else if (wait_q == LAST_WAIT) begin
                  valid0_q   <= 1'b0;
                  valid1_q   <= 1'b0;
                  pulse_q    <= 1'b1;
                  excl_vld_q <= 1'b1;
                  excl_car_q <= offer_car_q;
                  state_q    <= IDLE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign assign_valid0_o = valid0_q;
   assign assign_valid1_o = valid1_q;
   assign assign_floor_o  = floor_q;
   assign pending_o       = pending_q;
   assign assigned_o      = assigned_q;
   assign owner_o         = owner_q;
   assign timeout_pulse_o = pulse_q;

endmodule
